// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream register slice: output register plus skid register.
// Every output, including s_axis_tready, comes straight from a flop.
module axis_skid_buf #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state;
    logic                  out_valid;
    logic                  out_last;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  skid_valid;
    logic                  skid_last;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  s_ready_r;
    logic                  accept;

    // s_ready_r is low only in FULL, so an accept can never arrive while the skid is occupied.
    assign accept = s_axis_tvalid && s_ready_r;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
            s_ready_r  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    s_ready_r <= 1'b1;
                    if (accept) begin
                        out_data  <= s_axis_tdata;
                        out_last  <= s_axis_tlast;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && m_axis_tready) begin
                        out_data <= s_axis_tdata;
                        out_last <= s_axis_tlast;
                    end else if (accept) begin
                        // Output stalled: park the beat offered this cycle and close the input.
                        skid_data  <= s_axis_tdata;
                        skid_last  <= s_axis_tlast;
                        skid_valid <= 1'b1;
                        s_ready_r  <= 1'b0;
                        state      <= FULL;
                    end else if (m_axis_tready) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (m_axis_tready) begin
                        out_data   <= skid_data;
                        out_last   <= skid_last;
                        skid_valid <= 1'b0;
                        s_ready_r  <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    out_valid  <= 1'b0;
                    skid_valid <= 1'b0;
                    s_ready_r  <= 1'b0;
                    state      <= EMPTY;
                end
            endcase
        end
    end

    assign s_axis_tready = s_ready_r;
    assign m_axis_tdata  = out_data;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_last;

endmodule

// File: tb/tb_axis_skid_buf.sv
// Directed and random bench for axis_skid_buf with an order/occupancy scoreboard.
module tb_axis_skid_buf;

    localparam int DW = 16;

    logic          aclk;
    logic          areset;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;

    int total;
    int bad;
    bit mon_en;

    logic [DW:0] exp_q[$];
    bit          stall_prev;
    logic [DW:0] held;

    axis_skid_buf #(.DATA_WIDTH(DW)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [DW-1:0] dat, input logic lst);
        s_axis_tvalid = vld;
        s_axis_tdata  = dat;
        s_axis_tlast  = lst;
    endtask

    // Scoreboard: sampled mid-cycle, when inputs and outputs are both settled.
    always @(negedge aclk) begin
        if (!mon_en) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            check_eq("occ_vld", 32'(m_axis_tvalid), 32'(exp_q.size() > 0));
            check_eq("occ_rdy", 32'(s_axis_tready), 32'(exp_q.size() < 2));
            if (stall_prev && m_axis_tvalid)
                check_eq("stable", 32'({m_axis_tlast, m_axis_tdata}), 32'(held));
            if (m_axis_tvalid && m_axis_tready && exp_q.size() > 0)
                check_eq("order", 32'({m_axis_tlast, m_axis_tdata}), 32'(exp_q.pop_front()));
            if (s_axis_tvalid && s_axis_tready)
                exp_q.push_back({s_axis_tlast, s_axis_tdata});
            stall_prev = m_axis_tvalid && !m_axis_tready;
            held       = {m_axis_tlast, m_axis_tdata};
        end
    end

    initial begin
        int n;
        int cyc;
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        areset = 1'b1;
        m_axis_tready = 1'b1;
        drive(1'b1, 16'hDEAD, 1'b0);

        // Reset held 3 cycles with valid offered
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_mvld", 32'(m_axis_tvalid), 32'd0);
            check_eq("rst_srdy", 32'(s_axis_tready), 32'd0);
        end
        areset = 1'b0;
        step();
        check_eq("rel_srdy", 32'(s_axis_tready), 32'd1);
        check_eq("rel_mvld", 32'(m_axis_tvalid), 32'd0);
        drive(1'b0, 16'h0000, 1'b0);
        mon_en = 1'b1;
        step();

        // Back-to-back streaming 0x0001..0x0010
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, DW'(i + 1), i == 15);
            step();
            check_eq("strm_vld", 32'(m_axis_tvalid), 32'd1);
            check_eq("strm_dat", 32'(m_axis_tdata), 32'(i + 1));
            check_eq("strm_lst", 32'(m_axis_tlast), 32'(i == 15));
        end
        drive(1'b0, 16'h0000, 1'b0);
        step();
        check_eq("strm_end", 32'(m_axis_tvalid), 32'd0);

        // Skid capture: stall with 0xA0 on the output
        drive(1'b1, 16'h00A0, 1'b0);
        step();
        check_eq("skid_a0", 32'(m_axis_tdata), 32'h00A0);
        m_axis_tready = 1'b0;
        drive(1'b1, 16'h00A1, 1'b0);
        step();
        check_eq("skid_hold", 32'(m_axis_tdata), 32'h00A0);
        check_eq("skid_srdy", 32'(s_axis_tready), 32'd0);
        drive(1'b1, 16'h00A2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_dat", 32'(m_axis_tdata), 32'h00A0);
            check_eq("stall_vld", 32'(m_axis_tvalid), 32'd1);
            check_eq("stall_rdy", 32'(s_axis_tready), 32'd0);
        end
        m_axis_tready = 1'b1;
        step();
        check_eq("rel_a1", 32'(m_axis_tdata), 32'h00A1);
        check_eq("rel_rdy", 32'(s_axis_tready), 32'd1);
        step();
        check_eq("rel_a2", 32'(m_axis_tdata), 32'h00A2);
        drive(1'b1, 16'h00A3, 1'b1);
        step();
        check_eq("rel_a3", 32'(m_axis_tdata), 32'h00A3);
        check_eq("rel_a3l", 32'(m_axis_tlast), 32'd1);
        drive(1'b0, 16'h0000, 1'b0);
        step();
        check_eq("skid_end", 32'(m_axis_tvalid), 32'd0);

        // Bubble: single beat with tlast
        drive(1'b1, 16'h1234, 1'b1);
        step();
        check_eq("bub_vld", 32'(m_axis_tvalid), 32'd1);
        check_eq("bub_dat", 32'(m_axis_tdata), 32'h1234);
        check_eq("bub_lst", 32'(m_axis_tlast), 32'd1);
        drive(1'b0, 16'h0000, 1'b0);
        step();
        check_eq("bub_off", 32'(m_axis_tvalid), 32'd0);
        step();
        check_eq("bub_off2", 32'(m_axis_tvalid), 32'd0);

        // Random stress
        n   = 0;
        cyc = 0;
        while (n < 10000 && cyc < 60000) begin
            drive(1'($urandom), DW'($urandom), 1'($urandom));
            m_axis_tready = 1'($urandom);
            #1;
            if (s_axis_tvalid && s_axis_tready) n++;
            step();
            cyc++;
        end
        check_eq("rand_beats", 32'(n), 32'd10000);
        drive(1'b0, 16'h0000, 1'b0);
        m_axis_tready = 1'b1;
        repeat (4) step();
        check_eq("rand_drain", 32'(exp_q.size()), 32'd0);
        check_eq("rand_idle", 32'(m_axis_tvalid), 32'd0);

        // Reset while FULL
        m_axis_tready = 1'b0;
        drive(1'b1, 16'h0011, 1'b0);
        step();
        drive(1'b1, 16'h0022, 1'b1);
        step();
        check_eq("full_rdy", 32'(s_axis_tready), 32'd0);
        check_eq("full_vld", 32'(m_axis_tvalid), 32'd1);
        mon_en = 1'b0;
        areset = 1'b1;
        drive(1'b1, 16'h0033, 1'b0);
        repeat (2) begin
            step();
            check_eq("mrst_vld", 32'(m_axis_tvalid), 32'd0);
            check_eq("mrst_rdy", 32'(s_axis_tready), 32'd0);
            check_eq("mrst_lst", 32'(m_axis_tlast), 32'd0);
            check_eq("mrst_dat", 32'(m_axis_tdata), 32'd0);
        end
        areset = 1'b0;
        m_axis_tready = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        step();
        check_eq("mrel_rdy", 32'(s_axis_tready), 32'd1);
        check_eq("mrel_vld", 32'(m_axis_tvalid), 32'd0);
        mon_en = 1'b1;
        drive(1'b1, 16'h0055, 1'b1);
        step();
        check_eq("post_vld", 32'(m_axis_tvalid), 32'd1);
        check_eq("post_dat", 32'(m_axis_tdata), 32'h0055);
        drive(1'b0, 16'h0000, 1'b0);
        step();
        check_eq("post_alone", 32'(m_axis_tvalid), 32'd0);
        step();
        check_eq("post_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
